// File: rtl/sys_defs.sv
// Shared datapath definitions for the PE array: psum packet format,
// numeric widths and per-layer ofmap row lengths.
package sys_defs;
  localparam int PSUM_WIDTH    = 12;
  localparam int PSUM_FRAC     = 5;
  localparam int ACT_WIDTH     = 8;
  localparam int ACT_FRAC      = 7;
  localparam int ACT_LSHIFT    = ACT_FRAC - PSUM_FRAC;
  localparam int NUM_FILTERS   = 4;
  localparam int FIDX_WIDTH    = 2;
  localparam int L1_OFMAP_SIZE = 55;
  localparam int L2_OFMAP_SIZE = 27;
  localparam int L3_OFMAP_SIZE = 13;

  typedef struct packed {
    logic                  valid;
    logic [FIDX_WIDTH-1:0] filter_idx;
    logic [PSUM_WIDTH-1:0] psum;
  } PSUM_PACKET;
endpackage

// File: rtl/psum_requant.sv
// ReLU + left shift + positive saturation from psum format to the 8-bit
// activation format. Purely combinational.
module psum_requant #(
  parameter int PSUM_W     = 12,
  parameter int OUT_W      = 8,
  parameter int OUT_LSHIFT = 2
) (
  input  logic [PSUM_W-1:0] i_psum,
  output logic [OUT_W-1:0]  o_data
);
  localparam int SW = PSUM_W + OUT_LSHIFT;
  localparam logic [SW-1:0] MAXV = SW'((1 << (OUT_W - 1)) - 1);

  logic [SW-1:0] w_shift;

  // Widen before shifting so large positives saturate instead of wrapping.
  assign w_shift = i_psum[PSUM_W-1] ? '0 : ({{OUT_LSHIFT{1'b0}}, i_psum} << OUT_LSHIFT);
  assign o_data  = (w_shift > MAXV) ? OUT_W'(MAXV) : w_shift[OUT_W-1:0];
endmodule

// File: rtl/psum_collector.sv
// Bottom-of-column psum sink: acks packets, stores one ofmap row per filter,
// checks filter ordering, and serves raw/requantised reads.
module psum_collector
  import sys_defs::*;
#(
  parameter int NUM_FILTER = NUM_FILTERS,
  parameter int OFMAP_SIZE = L1_OFMAP_SIZE,
  parameter int PSUM_W     = PSUM_WIDTH,
  parameter int OUT_W      = ACT_WIDTH,
  parameter int OUT_LSHIFT = ACT_LSHIFT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  PSUM_PACKET            psum_in,
  output logic                  psum_ack_out,
  input  logic                  stall,
  input  logic                  rd_en,
  input  logic [FIDX_WIDTH-1:0] rd_filter,
  input  logic [5:0]            rd_addr,
  output logic                  rd_valid,
  output logic [PSUM_W-1:0]     rd_raw,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            count
);
  localparam int PTR_W = $clog2(OFMAP_SIZE + 1);
  localparam logic [PTR_W-1:0] OFM    = PTR_W'(OFMAP_SIZE);
  localparam logic [PTR_W-1:0] OFM_M1 = PTR_W'(OFMAP_SIZE - 1);
  localparam logic [5:0]       RD_LIM = 6'(OFMAP_SIZE);
  localparam logic [FIDX_WIDTH-1:0] FLAST = FIDX_WIDTH'(NUM_FILTER - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

  state_e                          r_state, w_state_nxt;
  logic                            r_ack, r_err;
  logic [7:0]                      r_count;
  logic [FIDX_WIDTH-1:0]           r_exp_idx;
  logic [NUM_FILTER-1:0][PTR_W-1:0] r_wr_ptr;
  logic [PSUM_W-1:0]               r_mem [NUM_FILTER][OFMAP_SIZE];

  logic                  w_accept, w_room, w_last, w_rd_in;
  logic [FIDX_WIDTH-1:0] w_fidx;
  logic [5:0]            w_rd_col;
  logic [PSUM_W-1:0]     w_rd_word;
  logic [OUT_W-1:0]      w_rq;

  assign w_fidx   = psum_in.filter_idx;
  // start takes priority, so a packet arriving with start is left un-acked.
  assign w_accept = (r_state == S_COLLECT) && psum_in.valid && !stall && !r_ack && !start;
  assign w_room   = r_wr_ptr[w_fidx] < OFM;

  // This accept completes the row if its filter fills up and all others are full.
  always_comb begin
    w_last = w_accept && w_room;
    for (int f = 0; f < NUM_FILTER; f++) begin
      if (FIDX_WIDTH'(f) == w_fidx) begin
        if (r_wr_ptr[f] != OFM_M1) w_last = 1'b0;
      end else if (r_wr_ptr[f] != OFM) begin
        w_last = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start)                                 w_state_nxt = S_COLLECT;
    else if (r_state == S_COLLECT && w_last)   w_state_nxt = S_DONE;
  end

  always_comb begin
    busy = (r_state == S_COLLECT);
    done = (r_state == S_DONE);
  end

  assign w_rd_in  = rd_addr < RD_LIM;
  assign w_rd_col = w_rd_in ? rd_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_count   <= '0;
      r_exp_idx <= '0;
      r_wr_ptr  <= '0;
    end else begin
      r_ack <= w_accept;
      if (start) begin
        r_err     <= 1'b0;
        r_count   <= '0;
        r_exp_idx <= '0;
        r_wr_ptr  <= '0;
      end else begin
        if (w_accept) begin
          r_exp_idx <= (w_fidx == FLAST) ? '0 : w_fidx + 1'b1;
          if (w_fidx != r_exp_idx) r_err <= 1'b1;
          if (w_room) begin
            r_wr_ptr[w_fidx] <= r_wr_ptr[w_fidx] + 1'b1;
            r_count          <= r_count + 8'd1;
          end else begin
            r_err <= 1'b1;
          end
        end
        if (rd_en && !w_rd_in) r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_room) r_mem[w_fidx][r_wr_ptr[w_fidx]] <= psum_in.psum;
  end

  assign w_rd_word = w_rd_in ? r_mem[rd_filter][w_rd_col] : '0;

  psum_requant #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .OUT_LSHIFT(OUT_LSHIFT)) u_rq (
    .i_psum (w_rd_word),
    .o_data (w_rq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_raw   <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_raw  <= w_rd_word;
        rd_data <= w_rq;
      end
    end
  end

  assign psum_ack_out = r_ack;
  assign error        = r_err;
  assign count        = r_count;
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sink at the bottom of a PE column: consumes the PSUM_PACKET stream leaving the last PE and returns the per-packet ack that the PE waits on.
- Stores one ofmap row per filter: NUM_FILTER x OFMAP_SIZE raw psums.
- Checks the stream ordering and signals completion.
- Exposes a registered read port returning raw and ReLU/requantised (8-bit, ifmap format) values to the global buffer.

Parameters:
- NUM_FILTER, 4: filters interleaved per packet stream; filter_idx range.
- OFMAP_SIZE, 55: outputs per filter per row (L1 default).
- PSUM_W, 12: psum width, signed, 5 fractional bits.
- OUT_W, 8: requantised output width, signed, 7 fractional bits.
- OUT_LSHIFT, 2: left shift converting psum format to output format.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: clear pointers/flags, begin collecting
- psum_in  in  PSUM_PACKET  {valid, filter_idx[1:0], psum[PSUM_W-1:0]} from last PE
- psum_ack_out  out  1  packet accepted; PE drops/advances valid on seeing it
- stall  in  1  downstream busy; no acceptance while high
- rd_en  in  1  read request
- rd_filter  in  2  read filter index
- rd_addr  in  6  read column, 0..OFMAP_SIZE-1
- rd_valid  out  1  rd_data/rd_raw valid
- rd_raw  out  PSUM_W  stored psum
- rd_data  out  OUT_W  requantised value
- busy  out  1  state == COLLECT
- done  out  1  state == DONE
- error  out  1  sticky protocol error
- count  out  8  total packets accepted this round

Behaviour:
- Reset: state IDLE; psum_ack_out, rd_valid, done, busy, error = 0; count and all wr_ptr = 0; rd_raw and rd_data = 0. Memory contents are not reset.
- States: IDLE -start-> COLLECT -(all wr_ptr == OFMAP_SIZE)-> DONE -start-> COLLECT.
- start in any state: wr_ptr[*], count, expected_idx and error cleared next cycle; state becomes COLLECT.
- start on the same cycle as an accept: start wins and the packet is not acked.
- Accept condition in cycle N: state == COLLECT, psum_in.valid, !stall, !psum_ack_out.
  - On accept, capture filter_idx/psum in N.
  - psum_ack_out = 1 in cycle N+1 for exactly one cycle.
  - Back-to-back accepts are therefore at most every 2 cycles; valid held through the ack cycle is never double-counted.
- On accept:
  - If wr_ptr[f] < OFMAP_SIZE: mem[f][wr_ptr[f]] <= psum, wr_ptr[f]++, count++.
  - Else: data dropped, still acked, error <= 1.
- Ordering: expected_idx starts at 0 and advances modulo NUM_FILTER per accept. If filter_idx != expected_idx, error <= 1; data is still stored by its own filter_idx, and expected_idx <= filter_idx+1.
- Completion: when the final accept makes every wr_ptr == OFMAP_SIZE, move to DONE on the following cycle and hold done high. In DONE and IDLE, valid is ignored and no ack is issued.
- Stall is ignored when not in COLLECT. Stall high on an ack cycle does not cancel the ack already issued.
- Read path:
  - rd_en in cycle N gives rd_valid/rd_raw/rd_data in N+1.
  - Allowed in any state; reads during COLLECT return current contents.
  - rd_addr >= OFMAP_SIZE: rd_valid = 1, data 0, error <= 1.
  - Simultaneous write to the same location: read returns the old value.
- Requant: r = max(psum, 0); s = r << OUT_LSHIFT; rd_data = (s > 2^(OUT_W-1)-1) ? 2^(OUT_W-1)-1 : s. Never negative.
- Reset mid-COLLECT: returns to IDLE; any pending ack is cancelled.

Decomposition:
- Shared package (sys_defs): PSUM_PACKET typedef, L1/L2/L3 OFMAP_SIZE constants, PSUM/activation widths.
- Collector-local FSM state enum stays in this module.
- One combinational sub-module, psum_requant (ReLU + shift + saturate), reused later by the pooling/output stage.
- Storage is an inferred NUM_FILTER x OFMAP_SIZE register array.

Test Plan:
- start, then 220 packets with filter_idx 0,1,2,3 repeating and psum = column*4, valid held until ack -> 220 acks; done after the last; count = 220; error = 0; read (2,10) gives rd_raw = 40, rd_data = 127.
- Requant: psum 12'h010 -> rd_data 8'h40; 12'hFF0 -> 0; 12'h7FF -> 127; 12'h008 -> 8'h20.
- Hold stall high for 100 cycles while valid is asserted -> no ack and count unchanged; release -> ack 1 cycle after the first non-stalled valid cycle.
- Out-of-order filter_idx sequence 0,2 -> error = 1 after the second ack; value stored at (2,0); the next expected index is 3.
- A 56th packet for filter 0 before the others complete -> acked, dropped, error = 1, wr_ptr[0] stays 55.
- rst asserted mid-COLLECT after 37 packets -> busy = 0, count = 0, no ack pending; a new start collects a full round normally.
